// File: rtl/fma_dot_sequencer_if.sv
// Operand-pair stream into the dot-product sequencer.
// Latency: none, wires only.
// Backpressure: a pair transfers on a cycle where in_valid and in_ready are both high.
interface fma_dot_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;

  // Producer of operand pairs
  modport master (
    output in_valid,
    output in_a,
    output in_b,
    input  in_ready
  );

  // Sequencer side
  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    output in_ready
  );
endinterface

// File: rtl/fma_dot_sequencer.sv
// Sequences a binary32 dot product through an external combinational FMA: acc = init + sum(a*b).
// Latency: 2 cycles per element plus 1 DONE cycle (2*len+1 from start); len==0 finishes the next cycle.
// Backpressure: in_ready is high only in LOAD and never depends on in_valid; LOAD waits for data indefinitely.
module fma_dot_sequencer #(
  parameter int LEN_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  input  logic [31:0]          init_fp,
  fma_dot_sequencer_if.slave   op,
  output logic [31:0]          fma_a,
  output logic [31:0]          fma_b,
  output logic [31:0]          fma_c,
  input  logic [31:0]          fma_out,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          result,
  output logic [LEN_W-1:0]     count,
  output logic                 ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        result_q, result_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  // Next-state and datapath updates; every field defaults to hold
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    result_d    = result_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    ovf_d       = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = init_fp;
          count_d = '0;
          ovf_d   = 1'b0;
          if (len != '0) begin
            remaining_d = len;
            state_d     = S_LOAD;
          end else begin
            // Empty vector: the seed is the answer, skip straight to the done pulse
            result_d = init_fp;
            state_d  = S_DONE;
          end
        end
      end

      S_LOAD: begin
        if (op.in_valid) begin
          a_d     = op.in_a;
          b_d     = op.in_b;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        // FMA inputs have been stable since the LOAD edge, so fma_out is settled here
        acc_d       = fma_out;
        count_d     = count_q + LEN_W'(1);
        remaining_d = remaining_q - LEN_W'(1);
        ovf_d       = ovf_q | (fma_out[30:23] == 8'hFF);
        state_d     = (remaining_q == LEN_W'(1)) ? S_DONE : S_LOAD;
      end

      S_DONE: begin
        result_d = acc_q;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously so a reset aborts any run in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      remaining_q <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  // FMA operands come straight from flops so they are glitch-free through EXEC
  assign fma_a = a_q;
  assign fma_b = b_q;
  assign fma_c = acc_q;

  assign op.in_ready = (state_q == S_LOAD);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  // During the done pulse the final value still lives in acc; afterwards result_q holds it
  assign result      = done ? acc_q : result_q;
  assign count       = count_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_fma_dot_sequencer.sv
// Directed bench for fma_dot_sequencer with a behavioural binary32 FMA beside it.
// Expected results are queued at each start and checked when done pulses.
// Operand presentation follows in_ready; every wait is bounded.
module tb_fma_dot_sequencer;

  localparam int LEN_W = 5;

  logic              clk;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [31:0]       init_fp;
  logic [31:0]       fma_a, fma_b, fma_c, fma_out;
  logic              busy, done, ovf;
  logic [31:0]       result;
  logic [LEN_W-1:0]  count;
  logic              force_inf;

  fma_dot_sequencer_if op_if ();

  fma_dot_sequencer #(.LEN_W(LEN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .len     (len),
    .init_fp (init_fp),
    .op      (op_if),
    .fma_a   (fma_a),
    .fma_b   (fma_b),
    .fma_c   (fma_c),
    .fma_out (fma_out),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .count   (count),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // binary32 -> real (denormals flushed; only normal values are exercised)
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e11;
    if (f[30:23] == 8'h00) return 0.0;
    e11 = 11'(int'(f[30:23]) - 127 + 1023);
    d = {f[31], e11, f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  // real -> binary32, round to nearest even
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [23:0] m;
    int e;
    d = $realtobits(r);
    if (d[62:0] == 63'b0) return {d[63], 31'b0};
    e = int'(d[62:52]) - 1023 + 127;
    m = {1'b0, d[51:29]};
    if (d[28] && ((|d[27:0]) || d[29])) m = m + 24'd1;
    if (m[23]) begin
      e = e + 1;
      m = '0;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'b0};
    if (e <= 0) return {d[63], 31'b0};
    return {d[63], e[7:0], m[22:0]};
  endfunction

  // Behavioural FMA, with an override to inject an infinity
  always_comb begin
    fma_out = r2f(f2r(fma_a) * f2r(fma_b) + f2r(fma_c));
    if (force_inf) fma_out = 32'h7F80_0000;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0;
  int rdy_cnt  = 0;
  logic [31:0] fma_c_q[$];
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;
  always @(negedge clk) if (op_if.in_ready) rdy_cnt <= rdy_cnt + 1;
  always @(negedge clk) if (!rst && busy && !op_if.in_ready && !done) fma_c_q.push_back(fma_c);

  typedef struct {
    logic [31:0]      res;
    logic [LEN_W-1:0] cnt;
    logic             ovf;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [31:0] r, input logic [LEN_W-1:0] c, input logic o);
    exp_t e;
    e.res = r;
    e.cnt = c;
    e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [LEN_W-1:0] l, input logic [31:0] init);
    start   = 1'b1;
    len     = l;
    init_fp = init;
    tick();
    start   = 1'b0;
  endtask

  // Wait for LOAD, optionally idle for gap cycles, then hand over one pair
  task automatic feed(input logic [31:0] a, input logic [31:0] b, input int gap);
    int n;
    n = 0;
    while (!op_if.in_ready && n < 50) begin
      tick();
      n++;
    end
    check("rdy_timeout", {31'b0, op_if.in_ready}, 32'd1);
    repeat (gap) begin
      op_if.in_valid = 1'b0;
      tick();
      check("gap_rdy", {31'b0, op_if.in_ready}, 32'd1);
    end
    op_if.in_valid = 1'b1;
    op_if.in_a     = a;
    op_if.in_b     = b;
    tick();
  endtask

  // Wait for done, score it against the queue head, then confirm the result holds in IDLE
  task automatic wait_done(input int lat, input int cs);
    int n;
    exp_t e;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check("done_seen", {31'b0, done}, 32'd1);
    check("sb_nonempty", {31'b0, (sb.size() != 0)}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("result", result, e.res);
      check("count", {27'b0, count}, {27'b0, e.cnt});
      check("ovf", {31'b0, ovf}, {31'b0, e.ovf});
      if (lat >= 0) check("latency", 32'(cyc - cs), 32'(lat));
      tick();
      check("idle_busy", {31'b0, busy}, 32'd0);
      check("done_1cyc", {31'b0, done}, 32'd0);
      check("result_hold", result, e.res);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  {31'b0, busy}, 32'd0);
    check({tag, "_rdy"},   {31'b0, op_if.in_ready}, 32'd0);
    check({tag, "_done"},  {31'b0, done}, 32'd0);
    check({tag, "_res"},   result, 32'd0);
    check({tag, "_cnt"},   {27'b0, count}, 32'd0);
    check({tag, "_ovf"},   {31'b0, ovf}, 32'd0);
    check({tag, "_fa"},    fma_a, 32'd0);
    check({tag, "_fb"},    fma_b, 32'd0);
    check({tag, "_fc"},    fma_c, 32'd0);
  endtask

  initial begin
    int cs;
    int rc0;
    int dc0;
    int ci;

    rst = 1'b0;
    start = 1'b0;
    len = '0;
    init_fp = '0;
    force_inf = 1'b0;
    op_if.in_valid = 1'b0;
    op_if.in_a = '0;
    op_if.in_b = '0;

    // Reset state
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    rst = 1'b0;
    tick();

    // len=2: 0 + 1*2 + 2*3 = 8.0, done 5 cycles after start
    ci = fma_c_q.size();
    sb_push(32'h4100_0000, 5'd2, 1'b0);
    cs = cyc;
    do_start(5'd2, 32'h0000_0000);
    feed(32'h3F80_0000, 32'h4000_0000, 0);
    feed(32'h4000_0000, 32'h4040_0000, 0);
    op_if.in_valid = 1'b0;
    wait_done(5, cs);
    check("t1_fc0", (fma_c_q.size() > ci) ? fma_c_q[ci] : 32'hDEAD_BEEF, 32'h0000_0000);
    check("t1_fc1", (fma_c_q.size() > ci + 1) ? fma_c_q[ci + 1] : 32'hDEAD_BEEF, 32'h4000_0000);

    // len=0: seed returned on the next cycle, no handshake offered
    rc0 = rdy_cnt;
    sb_push(32'h3F00_0000, 5'd0, 1'b0);
    cs = cyc;
    do_start(5'd0, 32'h3F00_0000);
    wait_done(1, cs);
    check("len0_no_rdy", 32'(rdy_cnt - rc0), 32'd0);

    // len=3 with 4-cycle gaps: 1 + 1 + 1 + 1 = 4.0
    ci = fma_c_q.size();
    sb_push(32'h4080_0000, 5'd3, 1'b0);
    do_start(5'd3, 32'h3F80_0000);
    feed(32'h3F80_0000, 32'h3F80_0000, 4);
    feed(32'h3F80_0000, 32'h3F80_0000, 4);
    feed(32'h3F80_0000, 32'h3F80_0000, 4);
    op_if.in_valid = 1'b0;
    wait_done(-1, 0);
    check("gap_nexec", 32'(fma_c_q.size() - ci), 32'd3);
    check("gap_fc0", (fma_c_q.size() > ci) ? fma_c_q[ci] : 32'hDEAD_BEEF, 32'h3F80_0000);
    check("gap_fc1", (fma_c_q.size() > ci + 1) ? fma_c_q[ci + 1] : 32'hDEAD_BEEF, 32'h4000_0000);
    check("gap_fc2", (fma_c_q.size() > ci + 2) ? fma_c_q[ci + 2] : 32'hDEAD_BEEF, 32'h4040_0000);

    // start pulsed while busy is ignored
    sb_push(32'h4100_0000, 5'd2, 1'b0);
    cs = cyc;
    do_start(5'd2, 32'h0000_0000);
    feed(32'h3F80_0000, 32'h4000_0000, 0);
    start = 1'b1;
    len = 5'd7;
    init_fp = 32'h1234_5678;
    tick();
    start = 1'b0;
    check("busy_start_busy", {31'b0, busy}, 32'd1);
    feed(32'h4000_0000, 32'h4040_0000, 0);
    op_if.in_valid = 1'b0;
    wait_done(5, cs);

    // Reset during the second EXEC of a len=3 run
    dc0 = done_cnt;
    sb_push(32'h4040_0000, 5'd3, 1'b0);
    do_start(5'd3, 32'h0000_0000);
    feed(32'h3F80_0000, 32'h3F80_0000, 0);
    feed(32'h3F80_0000, 32'h3F80_0000, 0);
    op_if.in_valid = 1'b0;
    check("pre_rst_exec", {31'b0, (busy && !op_if.in_ready && !done)}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("arst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    repeat (6) tick();
    check("no_done_after_rst", 32'(done_cnt - dc0), 32'd0);

    // Fresh run after the abort
    sb_push(32'h4100_0000, 5'd2, 1'b0);
    cs = cyc;
    do_start(5'd2, 32'h0000_0000);
    feed(32'h3F80_0000, 32'h4000_0000, 0);
    feed(32'h4000_0000, 32'h4040_0000, 0);
    op_if.in_valid = 1'b0;
    wait_done(5, cs);

    // Infinity out of the FMA sets the sticky ovf
    sb_push(32'h7F80_0000, 5'd1, 1'b1);
    cs = cyc;
    do_start(5'd1, 32'h0000_0000);
    feed(32'h3F80_0000, 32'h3F80_0000, 0);
    op_if.in_valid = 1'b0;
    force_inf = 1'b1;
    tick();
    force_inf = 1'b0;
    wait_done(3, cs);
    repeat (3) tick();
    check("ovf_sticky", {31'b0, ovf}, 32'd1);

    // Next accepted start clears it
    sb_push(32'h4000_0000, 5'd0, 1'b0);
    cs = cyc;
    do_start(5'd0, 32'h4000_0000);
    check("ovf_cleared", {31'b0, ovf}, 32'd0);
    wait_done(1, cs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fma_dot_sequencer.md
Name: fma_dot_sequencer

Overview:
- Sequential front-end that sits directly upstream of the combinational single-precision FMA and consumes that FMA's output.
- Accepts a stream of IEEE-754 binary32 operand pairs (a, b) over a valid/ready handshake.
- Drives the FMA with a, b and c = running accumulator, then registers the FMA result back into the accumulator.
- Produces the dot product init + sum(a_i*b_i) after len elements; the FMA is instantiated beside this block by the parent.

Parameters:
- LEN_W, 5, width of the vector-length and count fields (max len = 2^LEN_W - 1)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a new dot product; sampled only in IDLE
- len  input  LEN_W  number of (a,b) pairs; sampled with start
- init_fp  input  32  accumulator seed; sampled with start
- in_valid  input  1  operand pair present
- in_ready  output  1  block accepts operand pair this cycle
- in_a  input  32  operand a
- in_b  input  32  operand b
- fma_a  output  32  to FMA a_fp
- fma_b  output  32  to FMA b_fp
- fma_c  output  32  to FMA c_fp
- fma_out  input  32  from FMA out_fp; combinational function of fma_a/b/c
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when result is valid
- result  output  32  final accumulator; holds until next done
- count  output  LEN_W  elements accumulated in the current or last operation
- ovf  output  1  sticky: some accumulated fma_out had exponent field 8'hFF; cleared on accepted start

Behaviour:
- Reset (async, rst=1): state=IDLE; a_reg=b_reg=acc=result=0; remaining=count=0; done=in_ready=busy=ovf=0.
- Reset mid-operation aborts immediately; no done is produced.
- fma_a=a_reg, fma_b=b_reg and fma_c=acc are direct register outputs, so the FMA inputs are glitch-free and stable for the whole EXEC cycle.
- State IDLE:
  - start && len!=0: acc<=init_fp, remaining<=len, count<=0, ovf<=0, go LOAD.
  - start && len==0: result<=init_fp, count<=0, ovf<=0, done=1 next cycle (via DONE state, with acc<=init_fp), no operands consumed.
  - Without start: stay in IDLE.
- State LOAD: in_ready=1 (combinational from state only, never from in_valid). On in_valid: a_reg<=in_a, b_reg<=in_b, go EXEC. Without in_valid: stay, indefinitely.
- State EXEC: in_ready=0; FMA settles within the cycle. At the edge:
  - acc<=fma_out, count<=count+1, remaining<=remaining-1.
  - ovf<=ovf | (fma_out[30:23]==8'hFF).
  - remaining==1: go DONE; else go LOAD.
- State DONE: done=1 for exactly this cycle; result<=acc at the edge entering IDLE. result is also observable as acc during DONE, i.e. the value equals the final fma_out. Go IDLE.
- start asserted while busy is ignored (no queuing, no state change).
- Throughput: 2 cycles per element when in_valid is held high. Latency from start to done pulse = 2*len+1 cycles; the len==0 case gives done on the cycle after start.
- count wraps never: it is bounded by len ≤ 2^LEN_W-1.
- No arithmetic is done in this block; sign, exponent and mantissa handling belong entirely to the FMA. ovf only inspects fma_out's exponent field.
- in_a/in_b are ignored outside the LOAD handshake cycle.

Test Plan:
- Bench models fma_out as the correctly rounded a*b+c. Reset then start, len=2, init=0x00000000, pairs (0x3F800000,0x40000000),(0x40000000,0x40400000) with in_valid held -> done 5 cycles after start, result=0x41000000 (8.0), count=2, ovf=0.
- len=0, init=0x3F000000 -> done on the next cycle, result=0x3F000000, in_ready never asserted.
- len=3 with in_valid gapped 4 idle cycles between pairs (1.0*1.0 each, init 0x3F800000) -> in_ready stays high during gaps, result=0x40800000 (4.0), fma_c sequence 0x3F800000,0x40000000,0x40400000.
- Pulse start again while busy (at cycle 3 of a len=2 run) -> ignored; result and count match an undisturbed run.
- Assert rst during the second EXEC of a len=3 run -> all outputs 0 asynchronously, no done; a fresh start then completes normally.
- Force fma_out=0x7F800000 during one EXEC -> ovf=1 at done and stays 1 until the next accepted start clears it.
